mod461_residue_accum: RTL and testbench
=======================================

Name: mod461_residue_accum

Overview:
- Sequential consumer for the per-chunk residue LUTs of the mod-461 converter.
- Each LUT maps one 6-bit slice of a 500-bit operand to a 9-bit partial residue. This block takes those partial residues one per beat over a valid/ready stream and sums them mod 461.
- It emits the final residue of the whole operand, so it sits between the LUT bank/serialiser and the downstream modular datapath.

Parameters:
- MOD, 461, modulus; must be < 2^W.
- W, 9, residue width.
- MAX_TERMS, 84, maximum beats per frame (ceil(500/6)).
- CNT_W, 7, term-counter width; must satisfy 2^CNT_W > MAX_TERMS.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  partial residue beat valid.
- in_ready  out  1  block accepts beat.
- in_data  in  W  partial residue; nominally < MOD, full 0..2^W-1 accepted.
- in_last  in  1  final beat of frame.
- out_valid  out  1  frame result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  W  frame residue, always < MOD.
- out_count  out  CNT_W  number of beats in the frame.
- out_err  out  1  frame error flag, qualified by out_valid.

Behaviour:
- Clock and reset: one clock (clk). rst_n is asynchronous assert, active-low; deassertion is synchronised upstream.
- Reset state: state=ACC, acc=0, cnt=0, err=0, out_valid=0, out_data=0, out_count=0, out_err=0. in_ready is 1 after reset.
- States:
  - ACC: in_ready=1.
  - HOLD: in_ready=0, out_valid=1.
- Accept: a beat is accepted when in_valid & in_ready in ACC.
  - sum = acc + in_data, 10 bits, max 460+511=971.
  - red = sum reduced by conditional subtraction of MOD, applied twice: s1 = sum>=MOD ? sum-MOD : sum; red = s1>=MOD ? s1-MOD : s1.
  - acc<=red; cnt<=cnt+1.
- Frame close: the frame closes on an accepted beat with in_last=1, or on the accepted beat that makes cnt==MAX_TERMS.
  - On close: out_data<=red, out_count<=cnt+1, out_err<=err_next, state<=HOLD.
  - Latency: out_valid rises the cycle after the last beat.
- Forced close: if beat MAX_TERMS arrives with in_last=0, the frame closes with out_err=1. The next beat starts a new frame.
- HOLD:
  - out_data, out_count and out_err are held stable while out_ready=0.
  - On out_valid & out_ready: acc<=0, cnt<=0, err<=0, state<=ACC.
  - Next-frame beats cannot be accepted in the same cycle (in_ready=0 in HOLD). Throughput is one frame per (N+1) cycles.
- Reset mid-frame: partial accumulation is discarded. No output is produced for the truncated frame.
- Handshake: in_ready and out_valid are registered-state decodes only. There are no combinational in_valid→in_ready or out_ready→out_valid paths.
- err_next = err | forced_close (| range violation when the optional feature is compiled in).

Optional Feature:
- Macro: MOD461_RANGE_CHECK_EN.
  - Defined: any accepted in_data >= MOD sets sticky err for the current frame, so out_err=1 at close. The value is still fully reduced.
  - Undefined: out-of-range inputs are silently reduced. out_err reflects only forced close.

Decomposition:
- Shared package mod461_pkg holds:
  - MOD_461 constant, RES_W=9, MAX_TERMS_500=84.
  - typedef residue_t (logic [8:0]).
  - typedef state_e {ACC, HOLD}.
- One sub-module: mod461_add_reduce. It is combinational: residue_t a + 9-bit b → residue_t, using the two-stage conditional subtract. It is reusable by other mod-461 blocks.

Test Plan:
- Beats 460, 460(last) → out_data=459, out_count=2, out_err=0, out_valid exactly 1 cycle after second beat.
- Beats 511, 460(last) → 971→510→49; out_data=49. Exercises the double subtraction.
- Single beat 0 with last → out_data=0, out_count=1. Then out_ready low 5 cycles → in_ready=0 and outputs stable throughout.
- 84 beats of 100, last on 84th → out_data=102 (8400 mod 461), out_count=84, out_err=0.
- 85 beats of 1, no last → forced close after beat 84: out_data=84, out_err=1. Beat 85 starts a new frame (out_count=1 once it closes with last).
- Beat 500(last) → out_data=39. out_err=1 with MOD461_RANGE_CHECK_EN, 0 without.
- Reset asserted mid-frame after 3 beats → all outputs return to reset values immediately. The next frame starts from acc=0.

Source files
------------

// File: rtl/mod461_pkg.sv
// Shared constants and types for the mod-461 residue datapath.
package mod461_pkg;

    localparam int MOD_461       = 461;
    localparam int RES_W         = 9;
    localparam int MAX_TERMS_500 = 84;
    localparam int TERM_CNT_W    = 7;

    typedef logic [RES_W-1:0] residue_t;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/mod461_add_reduce.sv
// Combinational a + b mod 461 for a < 461 and any 9-bit b (sum <= 971).
// Two conditional subtractions are always enough for that input range.
module mod461_add_reduce
    import mod461_pkg::*;
(
    input  residue_t         a,
    input  logic [RES_W-1:0] b,
    output residue_t         y
);

    localparam logic [RES_W:0] MOD_EXT = (RES_W+1)'(MOD_461);

    logic [RES_W:0] sum;
    logic [RES_W:0] s1;
    logic [RES_W:0] s2;

    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
        s1  = (sum >= MOD_EXT) ? (sum - MOD_EXT) : sum;
        s2  = (s1 >= MOD_EXT) ? (s1 - MOD_EXT) : s1;
        y   = s2[RES_W-1:0];
    end

endmodule

// File: rtl/mod461_residue_accum.sv
// Streams per-chunk partial residues and emits their sum mod 461 per frame.
// Optional macro MOD461_RANGE_CHECK_EN flags frames containing inputs >= MOD.
module mod461_residue_accum
    import mod461_pkg::*;
#(
    parameter int MOD       = MOD_461,
    parameter int W         = RES_W,
    parameter int MAX_TERMS = MAX_TERMS_500,
    parameter int CNT_W     = TERM_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_err
);

    state_e           state_reg, state_next;
    residue_t         acc_reg, acc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             err_reg, err_next;
    logic [W-1:0]     out_data_reg, out_data_next;
    logic [CNT_W-1:0] out_count_reg, out_count_next;
    logic             out_err_reg, out_err_next;

    residue_t         red;
    logic             accept;
    logic [CNT_W-1:0] cnt_inc;
    logic             max_hit;
    logic             range_bad;
    logic             beat_err;

    mod461_add_reduce u_add_reduce (
        .a (acc_reg),
        .b (in_data),
        .y (red)
    );

    assign in_ready  = (state_reg == ACC);
    assign out_valid = (state_reg == HOLD);
    assign out_data  = out_data_reg;
    assign out_count = out_count_reg;
    assign out_err   = out_err_reg;

    assign accept  = in_valid & in_ready;
    assign cnt_inc = cnt_reg + CNT_W'(1);
    assign max_hit = (cnt_inc == CNT_W'(MAX_TERMS));

`ifdef MOD461_RANGE_CHECK_EN
    assign range_bad = (in_data >= W'(MOD));
`else
    assign range_bad = 1'b0;
`endif

    // Sticky frame error including this beat's contribution.
    assign beat_err = err_reg | (max_hit & ~in_last) | range_bad;

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        err_next       = err_reg;
        out_data_next  = out_data_reg;
        out_count_next = out_count_reg;
        out_err_next   = out_err_reg;

        case (state_reg)
            ACC: begin
                if (accept) begin
                    acc_next = red;
                    cnt_next = cnt_inc;
                    err_next = beat_err;
                    if (in_last || max_hit) begin
                        out_data_next  = red;
                        out_count_next = cnt_inc;
                        out_err_next   = beat_err;
                        state_next     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_next   = '0;
                    cnt_next   = '0;
                    err_next   = 1'b0;
                    state_next = ACC;
                end
            end
            default: state_next = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ACC;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            err_reg       <= 1'b0;
            out_data_reg  <= '0;
            out_count_reg <= '0;
            out_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            err_reg       <= err_next;
            out_data_reg  <= out_data_next;
            out_count_reg <= out_count_next;
            out_err_reg   <= out_err_next;
        end
    end

endmodule

// File: tb/tb_mod461_residue_accum.sv
// Randomized + directed bench for mod461_residue_accum against an arithmetic frame model.
module tb_mod461_residue_accum;

`ifdef MOD461_RANGE_CHECK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [8:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [8:0] out_data;
    logic [6:0] out_count;
    logic       out_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int data;
        int count;
        int err;
    } frame_t;

    frame_t exp_q[$];
    int     m_sum = 0;
    int     m_cnt = 0;
    int     m_err = 0;
    bit     rand_rdy = 1'b0;

    mod461_residue_accum dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: frame residue is the plain integer sum mod 461.
    task automatic model_beat(input int d, input bit l);
        frame_t f;
        m_sum = (m_sum + d) % 461;
        m_cnt++;
        if (RANGE_CHK && d >= 461) m_err = 1;
        if (l || m_cnt == 84) begin
            if (!l) m_err = 1;
            f.data  = m_sum;
            f.count = m_cnt;
            f.err   = m_err;
            exp_q.push_back(f);
            $display("frame queued: data=%0d count=%0d err=%0d", f.data, f.count, f.err);
            m_sum = 0;
            m_cnt = 0;
            m_err = 0;
        end
    endtask

    task automatic beat(input int d, input bit l);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 9'(d);
        in_last  = l;
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("beat_timeout", 0, 1);
        @(posedge clk);
        model_beat(d, l);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 0);
    endtask

    // Output monitor: compares each handshaken frame and checks holding stability.
    logic       held = 1'b0;
    logic [8:0] h_data;
    logic [6:0] h_count;
    logic       h_err;

    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else if (out_valid) begin
            if (held) begin
                check("hold_data", 32'(out_data), 32'(h_data));
                check("hold_count", 32'(out_count), 32'(h_count));
                check("hold_err", 32'(out_err), 32'(h_err));
                check("hold_in_ready", 32'(in_ready), 0);
            end
            if (out_ready) begin
                held = 1'b0;
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                end else begin
                    frame_t f;
                    f = exp_q.pop_front();
                    $display("frame out: data=%0d count=%0d err=%0d", out_data, out_count, out_err);
                    check("out_data", 32'(out_data), 32'(f.data));
                    check("out_count", 32'(out_count), 32'(f.count));
                    check("out_err", 32'(out_err), 32'(f.err));
                end
            end else begin
                held    = 1'b1;
                h_data  = out_data;
                h_count = out_count;
                h_err   = out_err;
            end
        end else begin
            held = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #2;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int len;
        int d;

        #1;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_count", 32'(out_count), 0);
        check("rst_out_err", 32'(out_err), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 460 + 460 -> 459, result exactly one cycle after the last beat
        beat(460, 1'b0);
        check("no_early_valid", 32'(out_valid), 0);
        beat(460, 1'b1);
        check("latency_valid", 32'(out_valid), 1);
        wait_drain();

        // 511 + 460 = 971 -> 49 needs both subtractions
        beat(511, 1'b0);
        beat(460, 1'b1);
        wait_drain();

        // single zero beat, then backpressure for five cycles
        out_ready = 1'b0;
        beat(0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 0);
            check("stall_valid", 32'(out_valid), 1);
            check("stall_data", 32'(out_data), 0);
            check("stall_count", 32'(out_count), 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();

        // full-length frame
        for (int i = 0; i < 84; i++) beat(100, i == 83);
        wait_drain();

        // forced close on beat 84, beat 85 opens a new frame
        for (int i = 0; i < 84; i++) beat(1, 1'b0);
        beat(1, 1'b1);
        wait_drain();

        // out-of-range input
        beat(500, 1'b1);
        wait_drain();

        // reset mid-frame discards the partial frame
        beat(7, 1'b0);
        beat(8, 1'b0);
        beat(9, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 1);
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_out_data", 32'(out_data), 0);
        check("midrst_out_count", 32'(out_count), 0);
        check("midrst_out_err", 32'(out_err), 0);
        m_sum = 0;
        m_cnt = 0;
        m_err = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        beat(5, 1'b1);
        wait_drain();

        // random frames with random backpressure
        rand_rdy = 1'b1;
        for (int f = 0; f < 25; f++) begin
            len = $urandom_range(1, 90);
            for (int i = 0; i < len; i++) begin
                d = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 511) : $urandom_range(0, 460);
                beat(d, i == len - 1);
            end
        end
        @(posedge clk);
        rand_rdy = 1'b0;
        #3;
        out_ready = 1'b1;
        wait_drain();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
